fifo_read_ctrl: RTL
===================

Name: fifo_read_ctrl

Overview:
Read-side controller of the asynchronous FIFO, in the rclk domain. It takes the write pointer already synchronised into rclk (Gray, 2-flop) and generates the Gray/binary read pointer, empty and almost-empty flags, and a fill level. It drives the synchronous-read dual-port RAM and presents first-word-fall-through data through a 2-entry valid/ready output buffer. Its Gray read pointer goes to the read-to-write synchroniser.

Parameters:
ADDRSIZE, 4, RAM address width; depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
DATASIZE, 8, data word width.
AEMPTY_THRESH, 2, raempty asserts when rlevel <= this value.

Ports:
rclk  in  1  read clock
rrst_n  in  1  async active-low reset
rq2_wptr  in  ADDRSIZE+1  write pointer, Gray, synchronised to rclk
rptr  out  ADDRSIZE+1  read pointer, Gray, registered, to read-to-write synchroniser
raddr  out  ADDRSIZE  RAM read address = binary read pointer [ADDRSIZE-1:0]
ren  out  1  RAM read enable, combinational
rmem_data  in  DATASIZE  RAM read data, valid 1 rclk after ren
rdata  out  DATASIZE  output data, registered
rvalid  out  1  rdata valid
rready  in  1  consumer accepts rdata
rempty  out  1  RAM holds no unread word, registered
raempty  out  1  almost empty, registered
rlevel  out  ADDRSIZE+1  words in RAM not yet read, registered

Behaviour:
- Reset (async, active-low; rrst_n is the only reset): rbin=0, rptr=0, rempty=1, raempty=1, rlevel=0, rvalid=0, rdata=0, skid empty, in_flight=0; ren=0 while rempty=1.
- Pointer: rbin_next = rbin + ren, mod 2**(ADDRSIZE+1). rgray_next = (rbin_next>>1) ^ rbin_next. rptr <= rgray_next. raddr = rbin[ADDRSIZE-1:0].
- Empty: rempty <= (rgray_next == rq2_wptr). Pessimistic by design: it deasserts only after the synchroniser latency. Full-width compare, so wrap-around is handled by the MSB.
- Level: wbin = Gray-to-binary(rq2_wptr). rlevel <= (wbin - rbin_next) mod 2**(ADDRSIZE+1), range 0..2**ADDRSIZE. raempty <= (that value <= AEMPTY_THRESH).
- Output buffer: head register (rdata/rvalid) plus 1-entry skid register. in_flight <= ren.
- pop = rvalid & rready.
- occ = rvalid + skid_valid + in_flight.
- ren = !rempty & (occ - pop < 2). This gives sustained 1 word/cycle with rready high and never overflows the buffer.
- Data landing when in_flight=1:
  - goes to head if the head is empty, or is popped with skid empty;
  - otherwise goes to skid.
- On pop with skid valid: skid moves to head; arriving data, if any, refills skid. Order is strictly FIFO.
- rdata/rvalid are stable while rvalid=1 and rready=0. rready with rvalid=0 has no effect.
- Latency: first word written reaches RAM-visible rq2_wptr, then rempty falls next cycle, ren the same cycle, rvalid 2 cycles after rempty falls.
- Reset mid-operation: all state clears immediately. Buffered or in-flight data is discarded. The write side must be reset together.

Test Plan:
- Reset with rq2_wptr=0 -> rempty=1, raempty=1, rlevel=0, rvalid=0, ren=0, rptr=0.
- Drive rq2_wptr from Gray 0 to 1 (00001), RAM[0]=0xA5, rready=0 -> rlevel=1, then rempty=0 and ren=1 with raddr=0; rvalid=1, rdata=0xA5 two cycles later; rptr=00001, rempty=1.
- rq2_wptr = Gray(8), RAM[0..7]=0..7, rready=1 -> rdata 0..7 on consecutive cycles with no bubble; raempty rises when rlevel<=2; rempty=1 after 8 reads.
- Same 8 words with rready low for 5 cycles mid-stream -> at most 2 words buffered, ren stalls, no loss or duplication, order 0..7 preserved.
- Stream 40 words (ADDRSIZE=4) in bursts -> rptr MSB toggles at 16 and 32, rempty correct across wrap, rlevel never exceeds 16.
- Assert rrst_n low while rvalid=1, skid full and in_flight=1 -> all outputs return to reset values asynchronously; no data appears after release.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of an asynchronous FIFO (rclk domain): Gray/binary read pointer,
// empty / almost-empty / level flags, and a 2-entry first-word-fall-through output buffer.
module fifo_read_ctrl #(
    parameter int ADDRSIZE      = 4,
    parameter int DATASIZE      = 8,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                ren,
    input  logic [DATASIZE-1:0] rmem_data,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
    input  logic                rready,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

    logic [PW-1:0]       r_rbin;
    logic [PW-1:0]       r_rptr;
    logic [PW-1:0]       r_rlevel;
    logic                r_rempty;
    logic                r_raempty;
    logic [DATASIZE-1:0] r_head;
    logic                r_head_v;
    logic [DATASIZE-1:0] r_skid;
    logic                r_skid_v;
    logic                r_in_flight;

    logic [PW-1:0] w_rbin_next;
    logic [PW-1:0] w_rgray_next;
    logic [PW-1:0] w_wbin;
    logic [PW-1:0] w_level_next;
    logic          w_pop;
    logic [1:0]    w_occ;
    logic [1:0]    w_avail;
    logic          w_ren;

    // Output handshake: a word transfers on a rclk edge where rvalid and rready are both high;
    // while rvalid=1 and rready=0, rdata/rvalid hold; rready with rvalid=0 is ignored.
    assign w_pop   = r_head_v & rready;
    assign w_occ   = {1'b0, r_head_v} + {1'b0, r_skid_v} + {1'b0, r_in_flight};
    assign w_avail = w_occ - {1'b0, w_pop};
    // Words already requested from the RAM count as buffered, so the buffer can never overflow.
    assign w_ren   = !r_rempty && (w_avail < 2'd2);

    assign w_rbin_next  = r_rbin + {{(PW-1){1'b0}}, w_ren};
    assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

    always_comb begin
        w_wbin = '0;
        for (int i = 0; i < PW; i++) begin
            w_wbin[i] = ^(rq2_wptr >> i);
        end
    end

    assign w_level_next = w_wbin - w_rbin_next;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rbin    <= '0;
            r_rptr    <= '0;
            r_rempty  <= 1'b1;
            r_raempty <= 1'b1;
            r_rlevel  <= '0;
        end else begin
            r_rbin    <= w_rbin_next;
            r_rptr    <= w_rgray_next;
            r_rempty  <= (w_rgray_next == rq2_wptr);
            r_raempty <= (w_level_next <= AE_TH);
            r_rlevel  <= w_level_next;
        end
    end

    // Head/skid buffer: data returning from the RAM lands in the head when it is free or
    // draining with an empty skid; otherwise in the skid. Skid always drains into the head first.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_head      <= '0;
            r_head_v    <= 1'b0;
            r_skid      <= '0;
            r_skid_v    <= 1'b0;
            r_in_flight <= 1'b0;
        end else begin
            r_in_flight <= w_ren;
            if (w_pop) begin
                if (r_skid_v) begin
                    r_head   <= r_skid;
                    r_head_v <= 1'b1;
                    if (r_in_flight) begin
                        r_skid <= rmem_data;
                    end
                    r_skid_v <= r_in_flight;
                end else begin
                    if (r_in_flight) begin
                        r_head <= rmem_data;
                    end
                    r_head_v <= r_in_flight;
                end
            end else if (r_in_flight) begin
                if (!r_head_v) begin
                    r_head   <= rmem_data;
                    r_head_v <= 1'b1;
                end else begin
                    r_skid   <= rmem_data;
                    r_skid_v <= 1'b1;
                end
            end
        end
    end

    assign rptr    = r_rptr;
    assign raddr   = r_rbin[ADDRSIZE-1:0];
    assign ren     = w_ren;
    assign rdata   = r_head;
    assign rvalid  = r_head_v;
    assign rempty  = r_rempty;
    assign raempty = r_raempty;
    assign rlevel  = r_rlevel;

endmodule
